// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer and exception merge.
// Optional forwarding tap enabled by defining PIPE_FWD_EN (requires DW >= 64).
module pipe_stage_buf #(
  parameter int DW    = 64,
  parameter int EXC_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Req,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [EXC_W-1:0] in_exc,
  input  logic [EXC_W-1:0] stage_exc,
  input  logic             in_delay,
  input  logic [31:0]      in_pc,
  input  logic             in_regwrite,
  input  logic [4:0]       in_a3,
  input  logic [1:0]       in_wdsel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [EXC_W-1:0] out_exc,
  output logic             out_delay,
  output logic [31:0]      out_pc,
  output logic             out_regwrite,
  output logic [4:0]       out_a3,
  output logic [1:0]       out_wdsel,
  output logic             fwd_valid,
  output logic [4:0]       fwd_a3,
  output logic [31:0]      fwd_data
);

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [EXC_W-1:0] exc;
    logic             delay;
    logic [31:0]      pc;
    logic             regwrite;
    logic [4:0]       a3;
    logic [1:0]       wdsel;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, in_entry;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   accept, drain;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid_q & out_ready;

  // The upstream exception is older than anything raised here, so it wins.
  always_comb begin
    in_entry.data     = in_data;
    in_entry.exc      = (in_exc != '0) ? in_exc : stage_exc;
    in_entry.delay    = in_delay;
    in_entry.pc       = in_pc;
    in_entry.regwrite = in_regwrite;
    in_entry.a3       = in_a3;
    in_entry.wdsel    = in_wdsel;
  end

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (Req) begin
      main_d       = '0;
      main_valid_d = 1'b0;
      skid_d       = '0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      skid_d       = '0;
      skid_valid_d = 1'b0;
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        if (accept) begin
          skid_d       = in_entry;
          skid_valid_d = 1'b1;
        end
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_d       = '0;
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_data     = main_q.data;
  assign out_exc      = main_q.exc;
  assign out_delay    = main_q.delay;
  assign out_pc       = main_q.pc;
  assign out_a3       = main_q.a3;
  assign out_wdsel    = main_q.wdsel;
  assign out_regwrite = main_valid_q & main_q.regwrite & (main_q.exc == '0);

`ifdef PIPE_FWD_EN
  always_comb begin
    fwd_data = '0;
    case (main_q.wdsel)
      2'b01:   fwd_data = main_q.data[31:0];
      2'b11:   fwd_data = main_q.data[63:32];
      default: fwd_data = '0;
    endcase
  end
  assign fwd_valid = out_regwrite;
  assign fwd_a3    = main_q.a3;
`else
  assign fwd_valid = 1'b0;
  assign fwd_a3    = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: queue-based stage model plus directed literal checks.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        reset, Req;
  logic        in_valid, in_ready;
  logic [63:0] in_data;
  logic [4:0]  in_exc, stage_exc;
  logic        in_delay;
  logic [31:0] in_pc;
  logic        in_regwrite;
  logic [4:0]  in_a3;
  logic [1:0]  in_wdsel;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_exc;
  logic        out_delay;
  logic [31:0] out_pc;
  logic        out_regwrite;
  logic [4:0]  out_a3;
  logic [1:0]  out_wdsel;
  logic        fwd_valid;
  logic [4:0]  fwd_a3;
  logic [31:0] fwd_data;

  int nChecks = 0;
  int nFail   = 0;
  bit chkEn   = 1'b0;
  bit fixData = 1'b0;
  logic [63:0] fixedData = 64'h0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DW(64), .EXC_W(5)) dut (
    .clk(clk), .reset(reset), .Req(Req),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_exc(in_exc), .stage_exc(stage_exc), .in_delay(in_delay),
    .in_pc(in_pc), .in_regwrite(in_regwrite), .in_a3(in_a3), .in_wdsel(in_wdsel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_exc(out_exc), .out_delay(out_delay), .out_pc(out_pc),
    .out_regwrite(out_regwrite), .out_a3(out_a3), .out_wdsel(out_wdsel),
    .fwd_valid(fwd_valid), .fwd_a3(fwd_a3), .fwd_data(fwd_data)
  );

  // The stage behaves as a two-deep FIFO: front is the main entry, room exists while fewer than two are held.
  typedef struct {
    logic [63:0] data;
    logic [4:0]  exc;
    logic        delay;
    logic [31:0] pc;
    logic        rw;
    logic [4:0]  a3;
    logic [1:0]  wdsel;
  } ent_t;

  ent_t q[$];
  ent_t newEnt;
  int   modelN;
  bit   modelAcc, modelDrn;

  always @(posedge clk) begin
    modelN   = q.size();
    modelAcc = in_valid && (modelN < 2);
    modelDrn = (modelN > 0) && out_ready;
    if (reset || Req) begin
      q.delete();
    end else begin
      if (modelDrn) void'(q.pop_front());
      if (modelAcc) begin
        newEnt.data  = in_data;
        newEnt.exc   = (in_exc != 0) ? in_exc : stage_exc;
        newEnt.delay = in_delay;
        newEnt.pc    = in_pc;
        newEnt.rw    = in_regwrite;
        newEnt.a3    = in_a3;
        newEnt.wdsel = in_wdsel;
        q.push_back(newEnt);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, compare all DUT outputs against the front of the model queue.
  ent_t        e;
  logic        expRw, expFwdV;
  logic [4:0]  expFwdA3;
  logic [31:0] expFwdD;

  always @(negedge clk) begin
    if (chkEn) begin
      if (q.size() > 0) e = q[0];
      else begin
        e.data = '0; e.exc = '0; e.delay = 1'b0; e.pc = '0;
        e.rw = 1'b0; e.a3 = '0; e.wdsel = '0;
      end
      expRw = (q.size() > 0) && e.rw && (e.exc == 0);
`ifdef PIPE_FWD_EN
      expFwdV  = expRw;
      expFwdA3 = e.a3;
      expFwdD  = (e.wdsel == 2'b01) ? e.data[31:0] : (e.wdsel == 2'b11) ? e.data[63:32] : 32'h0;
`else
      expFwdV  = 1'b0;
      expFwdA3 = '0;
      expFwdD  = '0;
`endif
      checkOutput("m_out_valid", {63'h0, out_valid}, {63'h0, q.size() > 0});
      checkOutput("m_in_ready", {63'h0, in_ready}, {63'h0, q.size() < 2});
      checkOutput("m_out_data", out_data, e.data);
      checkOutput("m_out_exc", {59'h0, out_exc}, {59'h0, e.exc});
      checkOutput("m_out_delay", {63'h0, out_delay}, {63'h0, e.delay});
      checkOutput("m_out_pc", {32'h0, out_pc}, {32'h0, e.pc});
      checkOutput("m_out_a3", {59'h0, out_a3}, {59'h0, e.a3});
      checkOutput("m_out_wdsel", {62'h0, out_wdsel}, {62'h0, e.wdsel});
      checkOutput("m_out_regwrite", {63'h0, out_regwrite}, {63'h0, expRw});
      checkOutput("m_fwd_valid", {63'h0, fwd_valid}, {63'h0, expFwdV});
      checkOutput("m_fwd_a3", {59'h0, fwd_a3}, {59'h0, expFwdA3});
      checkOutput("m_fwd_data", {32'h0, fwd_data}, {32'h0, expFwdD});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs; they are sampled at the next rising edge, after which the task returns.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [4:0] a3,
                               input logic rw, input logic [4:0] exc, input logic [4:0] sexc,
                               input logic ordy);
    in_valid    = v;
    in_pc       = pc;
    in_a3       = a3;
    in_regwrite = rw;
    in_exc      = exc;
    stage_exc   = sexc;
    in_delay    = pc[2];
    in_data     = fixData ? fixedData : {pc ^ 32'hA5A5_0000, ~pc};
    out_ready   = ordy;
    tick();
  endtask

  initial begin
    reset = 1'b1; Req = 1'b0;
    in_valid = 1'b0; in_data = '0; in_exc = '0; stage_exc = '0; in_delay = 1'b0;
    in_pc = '0; in_regwrite = 1'b0; in_a3 = '0; in_wdsel = 2'b01; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chkEn = 1'b1;

    checkOutput("rst_out_valid", {63'h0, out_valid}, 64'h0);
    checkOutput("rst_in_ready", {63'h0, in_ready}, 64'h1);
    checkOutput("rst_out_pc", {32'h0, out_pc}, 64'h0);
    checkOutput("rst_fwd_data", {32'h0, fwd_data}, 64'h0);

    applyStimulus(1'b1, 32'h3000, 5'd5, 1'b1, 5'd0, 5'd0, 1'b1);
    checkOutput("first_out_valid", {63'h0, out_valid}, 64'h1);
    checkOutput("first_out_pc", {32'h0, out_pc}, 64'h3000);
    checkOutput("first_out_regwrite", {63'h0, out_regwrite}, 64'h1);

    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 32'h3004 + 32'(4 * i), 5'(i + 1), 1'b1, 5'd0, 5'd0, 1'b1);
    checkOutput("stream_last_pc", {32'h0, out_pc}, 64'h3020);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("stream_empty", {63'h0, out_valid}, 64'h0);

    applyStimulus(1'b1, 32'h3000, 5'd5, 1'b1, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b1, 32'h3004, 5'd6, 1'b1, 5'd0, 5'd0, 1'b0);
    checkOutput("stall_in_ready", {63'h0, in_ready}, 64'h0);
    checkOutput("stall_pc", {32'h0, out_pc}, 64'h3000);
    applyStimulus(1'b1, 32'h3008, 5'd7, 1'b1, 5'd0, 5'd0, 1'b0);
    checkOutput("stall_hold_pc", {32'h0, out_pc}, 64'h3000);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("unstall_pc", {32'h0, out_pc}, 64'h3004);
    checkOutput("unstall_in_ready", {63'h0, in_ready}, 64'h1);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("unstall_empty", {63'h0, out_valid}, 64'h0);

    applyStimulus(1'b1, 32'h3100, 5'd3, 1'b1, 5'd0, 5'd4, 1'b1);
    checkOutput("exc_stage", {59'h0, out_exc}, 64'd4);
    checkOutput("exc_regwrite", {63'h0, out_regwrite}, 64'h0);
    applyStimulus(1'b1, 32'h3104, 5'd3, 1'b1, 5'd10, 5'd4, 1'b1);
    checkOutput("exc_upstream", {59'h0, out_exc}, 64'd10);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1);

    applyStimulus(1'b1, 32'h4000, 5'd8, 1'b1, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b1, 32'h4004, 5'd9, 1'b1, 5'd0, 5'd0, 1'b0);
    checkOutput("full_in_ready", {63'h0, in_ready}, 64'h0);
    Req = 1'b1;
    applyStimulus(1'b1, 32'h4008, 5'd10, 1'b1, 5'd0, 5'd0, 1'b0);
    Req = 1'b0;
    checkOutput("flush_out_valid", {63'h0, out_valid}, 64'h0);
    checkOutput("flush_in_ready", {63'h0, in_ready}, 64'h1);
    checkOutput("flush_out_pc", {32'h0, out_pc}, 64'h0);
    checkOutput("flush_out_a3", {59'h0, out_a3}, 64'h0);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("flush_dropped", {63'h0, out_valid}, 64'h0);

    fixData   = 1'b1;
    fixedData = {32'hBBBB0000, 32'h0000AAAA};
    in_wdsel  = 2'b01;
    applyStimulus(1'b1, 32'h5000, 5'd7, 1'b1, 5'd0, 5'd0, 1'b1);
`ifdef PIPE_FWD_EN
    checkOutput("fwd01_data", {32'h0, fwd_data}, 64'h0000AAAA);
    checkOutput("fwd01_a3", {59'h0, fwd_a3}, 64'd7);
    checkOutput("fwd01_valid", {63'h0, fwd_valid}, 64'h1);
`else
    checkOutput("fwd01_data", {32'h0, fwd_data}, 64'h0);
    checkOutput("fwd01_a3", {59'h0, fwd_a3}, 64'h0);
    checkOutput("fwd01_valid", {63'h0, fwd_valid}, 64'h0);
`endif
    in_wdsel = 2'b11;
    applyStimulus(1'b1, 32'h5004, 5'd7, 1'b1, 5'd0, 5'd0, 1'b1);
`ifdef PIPE_FWD_EN
    checkOutput("fwd11_data", {32'h0, fwd_data}, 64'hBBBB0000);
`else
    checkOutput("fwd11_data", {32'h0, fwd_data}, 64'h0);
`endif
    in_wdsel = 2'b00;
    applyStimulus(1'b1, 32'h5008, 5'd7, 1'b1, 5'd0, 5'd0, 1'b1);
    checkOutput("fwd00_data", {32'h0, fwd_data}, 64'h0);
    fixData  = 1'b0;
    in_wdsel = 2'b01;
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1);

    reset = 1'b1;
    applyStimulus(1'b1, 32'h6000, 5'd1, 1'b1, 5'd0, 5'd0, 1'b1);
    reset = 1'b0;
    checkOutput("reset_drop", {63'h0, out_valid}, 64'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
